// File: rtl/snake_pkg.sv
// Shared snake-game types: direction and FSM encodings, default playfield
// size (also used by the renderer and food generator), direction helper.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int SNAKE_GRID_W = 16;
    localparam int SNAKE_GRID_H = 12;

    // Opposite heading; a request for it would fold the snake onto its neck.
    function automatic dir_t reverse_dir(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_edge_tick.sv
// Rising-edge detector for the divided game clock. step_clk is already in the
// clk domain, so one register is enough; tick is high for the single clk cycle
// in which step_clk is seen high after having been low.
module snake_edge_tick (
    input  logic clk,
    input  logic reset,
    input  logic step_clk,
    output logic tick
);

    logic step_clk_q_reg;

    // Remember the previous step_clk level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_clk_q_reg <= 1'b0;
        end else begin
            step_clk_q_reg <= step_clk;
        end
    end

    assign tick = step_clk & ~step_clk_q_reg;

endmodule

// File: rtl/snake_motion_ctrl.sv
// Snake motion controller: turns each step_clk rising edge into one move of
// the snake, latches direction requests, applies growth and detects
// collisions. Segment 0 is the head; segments at index >= len are stale.
// Optional macro SNAKE_WRAP_EN: when defined the playfield edges wrap around
// and only self-collision ends the game.
module snake_motion_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W   = SNAKE_GRID_W,
    parameter int GRID_H   = SNAKE_GRID_H,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int IW = $clog2(MAX_LEN),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step_clk,
    input  logic          start,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          grow,
    input  logic [IW-1:0] rd_idx,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic          rd_valid,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] len,
    output logic          running,
    output logic          game_over,
    output logic          step_done
);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    state_t state_reg, state_next;
    dir_t   dir_reg, next_dir_reg, btn_dir;
    logic   btn_any;

    logic [LW-1:0] len_reg;
    logic          grow_pend_reg;
    logic          step_done_reg;

    logic tick;
    logic do_init, move_try, move_ok;
    logic grow_eff, growing;
    logic at_edge, wall_hit, self_hit;

    logic [XW-1:0] nh_x;
    logic [YW-1:0] nh_y;

    logic [MAX_LEN-1:0][XW-1:0] seg_x;
    logic [MAX_LEN-1:0][YW-1:0] seg_y;
    logic [MAX_LEN-1:0]         seg_hit;

    snake_edge_tick u_edge_tick (
        .clk      (clk),
        .reset    (reset),
        .step_clk (step_clk),
        .tick     (tick)
    );

    // Growth requested for this move: a pending pulse or one arriving with the tick.
    assign grow_eff = grow_pend_reg | (grow & (state_reg == ST_RUN));
    assign growing  = grow_eff & (len_reg < LW'(MAX_LEN));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus the init / move strobes.
    always_comb begin
        state_next = state_reg;
        do_init    = 1'b0;
        move_try   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DEAD: begin
                if (start) begin
                    do_init    = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    move_try = 1'b1;
                    if (wall_hit || self_hit) begin
                        state_next = ST_DEAD;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign move_ok = move_try & ~wall_hit & ~self_hit;

    // Button priority: up > down > left > right.
    always_comb begin
        btn_any = btn_up | btn_down | btn_left | btn_right;
        btn_dir = DIR_RIGHT;
        if (btn_up) begin
            btn_dir = DIR_UP;
        end else if (btn_down) begin
            btn_dir = DIR_DOWN;
        end else if (btn_left) begin
            btn_dir = DIR_LEFT;
        end
    end

    // Direction latch: accept any non-reversing request, commit it on a move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_reg      <= DIR_RIGHT;
            next_dir_reg <= DIR_RIGHT;
        end else if (do_init) begin
            dir_reg      <= DIR_RIGHT;
            next_dir_reg <= DIR_RIGHT;
        end else begin
            if (btn_any && (btn_dir != reverse_dir(dir_reg))) begin
                next_dir_reg <= btn_dir;
            end
            if (move_try) begin
                dir_reg <= next_dir_reg;
            end
        end
    end

    // Candidate head cell one step along next_dir, with the wrapped value at an edge.
    always_comb begin
        nh_x    = seg_x[0];
        nh_y    = seg_y[0];
        at_edge = 1'b0;
        case (next_dir_reg)
            DIR_UP: begin
                if (seg_y[0] == '0) begin
                    at_edge = 1'b1;
                    nh_y    = Y_MAX;
                end else begin
                    nh_y = seg_y[0] - 1'b1;
                end
            end
            DIR_DOWN: begin
                if (seg_y[0] == Y_MAX) begin
                    at_edge = 1'b1;
                    nh_y    = '0;
                end else begin
                    nh_y = seg_y[0] + 1'b1;
                end
            end
            DIR_LEFT: begin
                if (seg_x[0] == '0) begin
                    at_edge = 1'b1;
                    nh_x    = X_MAX;
                end else begin
                    nh_x = seg_x[0] - 1'b1;
                end
            end
            default: begin
                if (seg_x[0] == X_MAX) begin
                    at_edge = 1'b1;
                    nh_x    = '0;
                end else begin
                    nh_x = seg_x[0] + 1'b1;
                end
            end
        endcase
    end

    assign wall_hit = at_edge & ~WRAP_EN;
    assign self_hit = |seg_hit;

    // One register pair per segment; each takes its neighbour's cell on a move.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
        localparam bit              INIT_EN = (gi < INIT_LEN);
        localparam logic [XW-1:0]   INIT_X  = XW'(GRID_W / 2 - gi);
        localparam logic [YW-1:0]   INIT_Y  = YW'(GRID_H / 2);

        logic [XW-1:0] x_reg, src_x;
        logic [YW-1:0] y_reg, src_y;

        if (gi == 0) begin : g_head
            assign src_x = nh_x;
            assign src_y = nh_y;
        end else begin : g_body
            assign src_x = seg_x[gi-1];
            assign src_y = seg_y[gi-1];
        end

        // Load the start line on init, shift toward the tail on a clean move.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                x_reg <= '0;
                y_reg <= '0;
            end else if (do_init) begin
                if (INIT_EN) begin
                    x_reg <= INIT_X;
                    y_reg <= INIT_Y;
                end
            end else if (move_ok) begin
                x_reg <= src_x;
                y_reg <= src_y;
            end
        end

        assign seg_x[gi] = x_reg;
        assign seg_y[gi] = y_reg;

        // The tail only blocks the head when it stays put because the snake grows.
        assign seg_hit[gi] = (gi != 0) && (x_reg == nh_x) && (y_reg == nh_y) &&
                             ((gi + 2 <= int'(len_reg)) ||
                              ((gi + 1 == int'(len_reg)) && growing));
    end

    // Length, pending growth and the move-complete pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_reg       <= '0;
            grow_pend_reg <= 1'b0;
            step_done_reg <= 1'b0;
        end else begin
            step_done_reg <= move_ok;
            if (do_init) begin
                len_reg       <= LW'(INIT_LEN);
                grow_pend_reg <= 1'b0;
            end else if (move_try) begin
                grow_pend_reg <= 1'b0;
                if (move_ok && growing) begin
                    len_reg <= len_reg + 1'b1;
                end
            end else if (grow && (state_reg == ST_RUN)) begin
                grow_pend_reg <= 1'b1;
            end
        end
    end

    assign rd_x      = seg_x[rd_idx];
    assign rd_y      = seg_y[rd_idx];
    assign rd_valid  = LW'(rd_idx) < len_reg;
    assign head_x    = seg_x[0];
    assign head_y    = seg_y[0];
    assign len       = len_reg;
    assign running   = (state_reg == ST_RUN);
    assign game_over = (state_reg == ST_DEAD);
    assign step_done = step_done_reg;

endmodule
